// File: rtl/bit_window_capture.sv
// bit_window_capture: collects a serial bit stream into a word of up to
// MAXLEN bits (first bit in out_vec[0]) and presents it with a
// valid/ready handshake. Words longer than MAXLEN are closed early and
// flagged with out_trunc; their remaining bits are then dropped up to in_last.
module bit_window_capture #(
  parameter  int MAXLEN = 27,
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     out_len,
  output logic [MAXLEN-1:0] out_vec,
  output logic              out_trunc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);

  state_t              state, state_nxt;
  logic [LW-1:0]       len, len_nxt;
  logic [MAXLEN-1:0]   vec, vec_nxt;
  logic                trunc, trunc_nxt;
  logic [LW-1:0]       len_inc;
  logic                accept;

  // Only the held word blocks the input; collecting and draining both take beats.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  // len stays below MAXLEN outside HOLD, so this increment cannot wrap.
  assign len_inc   = len + LW'(1);

  assign out_len   = len;
  assign out_vec   = vec;
  assign out_trunc = trunc;

  // State, length, captured bits and truncation flag, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      vec   <= '0;
      trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      vec   <= vec_nxt;
      trunc <= trunc_nxt;
    end
  end

  // Next-state and next-datapath decode for the capture FSM.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    vec_nxt   = vec;
    trunc_nxt = trunc;
    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          for (int i = 0; i < MAXLEN; i++) begin
            if (len == LW'(i)) vec_nxt[i] = in_bit;
          end
          len_nxt = len_inc;
          if (in_last) begin
            state_nxt = HOLD;
            trunc_nxt = 1'b0;
          end else if (len_inc == MAXLEN_L) begin
            // Full window without an end marker: close now, drop the rest.
            state_nxt = HOLD;
            trunc_nxt = 1'b1;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = trunc ? DRAIN : IDLE;
          len_nxt   = '0;
          vec_nxt   = '0;
          trunc_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (accept && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_window_capture.sv
// Directed bench for bit_window_capture with a word-level reference model
// and a per-cycle compare process.
module tb_bit_window_capture;

  localparam int MAXLEN = 27;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [4:0]        out_len;
  logic [MAXLEN-1:0] out_vec;
  logic              out_trunc;

  int checks = 0;
  int failures = 0;

  bit_window_capture #(.MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_len(out_len), .out_vec(out_vec), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: bits gathered so far, a pending word, and a drop flag.
  int                m_cnt;
  logic [MAXLEN-1:0] m_word;
  logic              m_hold, m_drop, m_htrunc;
  int                m_hlen;
  logic [MAXLEN-1:0] m_hvec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_word <= '0; m_hold <= 1'b0; m_drop <= 1'b0;
      m_htrunc <= 1'b0; m_hlen <= 0; m_hvec <= '0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold <= 1'b0;
        m_drop <= m_htrunc;
      end
    end else if (in_valid) begin
      if (m_drop) begin
        if (in_last) m_drop <= 1'b0;
      end else if (in_last || (m_cnt + 1 == MAXLEN)) begin
        m_hold   <= 1'b1;
        m_hlen   <= m_cnt + 1;
        m_hvec   <= m_word | (MAXLEN'(in_bit) << m_cnt);
        m_htrunc <= !in_last;
        m_cnt    <= 0;
        m_word   <= '0;
      end else begin
        m_cnt  <= m_cnt + 1;
        m_word <= m_word | (MAXLEN'(in_bit) << m_cnt);
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_hold));
      chk("cmp_in_ready", 32'(in_ready), 32'(!m_hold));
      if (m_hold) begin
        chk("cmp_out_len", 32'(out_len), 32'(m_hlen));
        chk("cmp_out_vec", 32'(out_vec), 32'(m_hvec));
        chk("cmp_out_trunc", 32'(out_trunc), 32'(m_htrunc));
      end
    end
  end

  // Present one beat and wait (bounded) until it is accepted; returns after a falling edge.
  task automatic beat(input logic b, input logic l);
    int n;
    logic acc;
    in_valid = 1'b1; in_bit = b; in_last = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_word(input string name, input int len, input logic [MAXLEN-1:0] v, input logic tr);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_len"}, 32'(out_len), 32'(len));
    chk({name, "_vec"}, 32'(out_vec), 32'(v));
    chk({name, "_trunc"}, 32'(out_trunc), 32'(tr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_out_trunc", 32'(out_trunc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,1 with last on third bit.
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b1);
    idle_in();
    chk_word("w101", 3, 27'h5, 1'b0);
    @(negedge clk);
    chk("w101_after", 32'(out_valid), 32'd0);

    // Single-bit word.
    beat(1'b1, 1'b1);
    idle_in();
    chk_word("w1", 1, 27'h1, 1'b0);
    @(negedge clk);

    // 30 ones, last on beat 30: truncated at 27, rest drained.
    for (int i = 1; i <= 30; i++) begin
      beat(1'b1, (i == 30));
      if (i == 27) chk_word("wtrunc", 27, 27'h7FFFFFF, 1'b1);
    end
    idle_in();
    beat(1'b0, 1'b0); beat(1'b1, 1'b1);
    idle_in();
    chk_word("wpost_drain", 2, 27'h2, 1'b0);
    @(negedge clk);

    // Exactly 27 bits with last on bit 27: no truncation, no drain.
    for (int i = 0; i < 27; i++) beat((i % 3) == 0, (i == 26));
    idle_in();
    chk_word("w27", 27, 27'h1249249, 1'b0);
    @(negedge clk);
    chk("w27_ready_idle", 32'(in_ready), 32'd1);
    beat(1'b0, 1'b1);
    idle_in();
    chk_word("w27_next", 1, 27'h0, 1'b0);
    @(negedge clk);

    // Backpressure in HOLD for 5 cycles with a beat waiting.
    out_ready = 1'b0;
    beat(1'b1, 1'b0); beat(1'b1, 1'b1);
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk_word("bp_hold", 2, 27'h3, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    beat(1'b1, 1'b1);
    idle_in();
    chk_word("bp_next", 1, 27'h1, 1'b0);
    @(negedge clk);
    chk("bp_single_hs", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-word after 4 bits.
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_len", 32'(out_len), 32'd0);
    chk("arst_out_vec", 32'(out_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b0); beat(1'b1, 1'b1);
    idle_in();
    chk_word("arst_next", 2, 27'h2, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_window_capture.md
BIT_WINDOW_CAPTURE -- requirements
Module: bit_window_capture

Interface
REQ-001 Parameter: MAXLEN, default 27, maximum bits per captured word; the widths below assume the default.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_bit  input  1  serial data bit of the current beat.
REQ-006 in_last  input  1  current beat is the final bit of the word.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 out_valid  output  1  captured word is presented downstream.
REQ-009 out_ready  input  1  downstream accepts the presented word.
REQ-010 out_len  output  5  number of bits captured, 1..27.
REQ-011 out_vec  output  27  captured bits; the first bit received is in out_vec[0].
REQ-012 out_trunc  output  1  word was closed at MAXLEN without in_last.

Function
REQ-013 The block SHALL implement states IDLE, COLLECT, HOLD and DRAIN, encoded in a registered state variable.
REQ-014 A beat SHALL be accepted when in_valid && in_ready on a rising edge.
REQ-015 in_ready SHALL be 1 in IDLE, COLLECT and DRAIN, and 0 in HOLD.
REQ-016 out_valid SHALL be 1 only in HOLD.
REQ-017 out_len, out_vec and out_trunc SHALL be registered and stable for the whole of HOLD.
REQ-018 In IDLE or COLLECT, an accepted beat SHALL write in_bit to vec[len], increment len by 1, and leave all other vec bits unchanged.
REQ-019 IDLE SHALL move to COLLECT on an accepted beat with in_last=0 and len+1 < MAXLEN.
REQ-020 An accepted beat with in_last=1 SHALL move IDLE or COLLECT to HOLD with out_trunc=0, including a single-bit word (out_len=1).
REQ-021 An accepted beat that makes len+1 == MAXLEN with in_last=0 SHALL move to HOLD with out_trunc=1.
REQ-022 An accepted beat that makes len+1 == MAXLEN with in_last=1 SHALL move to HOLD with out_trunc=0.
REQ-023 HOLD SHALL exit on the first cycle with out_ready=1; that cycle is the handshake.
REQ-024 On the handshake, len, vec and out_trunc SHALL clear to 0.
REQ-025 On the handshake, the next state SHALL be DRAIN if out_trunc=1, otherwise IDLE.
REQ-026 Holding out_ready=1 continuously SHALL give one cycle of out_valid per word.
REQ-027 DRAIN SHALL discard accepted beats without updating vec or len.
REQ-028 DRAIN SHALL move to IDLE on an accepted beat with in_last=1.
REQ-029 Latency: out_valid SHALL assert on the cycle after the closing beat is accepted.
REQ-030 Throughput: at most one beat per cycle; the block SHALL NOT accept a beat in the handshake cycle (in_ready=0 in HOLD).
REQ-031 len SHALL never exceed MAXLEN and SHALL never wrap; no counter arithmetic SHALL overflow 5 bits.
REQ-032 in_bit and in_last SHALL be ignored when in_valid=0 or in_ready=0.
REQ-033 out_valid SHALL NOT drop in HOLD until the handshake.

Reset
REQ-034 When rst_n=0, state SHALL go to IDLE immediately (asynchronously).
REQ-035 When rst_n=0, len, out_vec and out_trunc SHALL clear to 0 asynchronously.
REQ-036 During and after reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-037 Reset asserted mid-word, in HOLD, or in DRAIN SHALL discard the partial or held word with no output handshake.
REQ-038 Deassertion of rst_n SHALL be synchronised externally; the block SHALL accept a beat on the first rising edge after deassertion.

Verification
REQ-039 Send bits 1,0,1 with in_last on the 3rd bit, out_ready=1 -> one out_valid pulse with out_len=3, out_vec=27'h5, out_trunc=0, then IDLE.
REQ-040 Send a single beat with in_bit=1 and in_last=1 -> out_len=1, out_vec=27'h1, out_trunc=0.
REQ-041 Send 30 beats of 1 with in_last on beat 30, out_ready=1 -> out_len=27, out_vec=27'h7FFFFFF, out_trunc=1; beats 28-30 are discarded in DRAIN; next word starts clean.
REQ-042 Send 27 bits with in_last on bit 27 -> out_trunc=0, no DRAIN, next beat accepted in IDLE.
REQ-043 Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and outputs stable throughout; release -> a single handshake and the next word captured correctly.
REQ-044 Pulse rst_n low asynchronously mid-word (after 4 bits) -> out_valid=0, len=0, out_vec=0; a subsequent 2-bit word yields out_len=2.
